// File: rtl/vote_pkg.sv
// Shared types and constants for the voting round controller.
// State encoding, the all-voted mask and a 3-bit popcount helper.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTING = 2'd1,
    TALLY  = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam logic [2:0] ALL_VOTED = 3'b111;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge pulse generator.
// Ports: clk, rst (async high), btn_i raw button, rise_o one-cycle pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Driven only from flops, so no input reaches the output combinationally.
  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/voter_33.sv
// Three-input majority voter (2-of-3).
// Ports: a, b, c votes in; y high when at least two are high.
module voter_33 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/vote_round_ctrl.sv
// Timed three-judge voting round: window, one-cycle tally, result display.
// Ports: clk, rst, start, btn_a/b/c in; busy, voting, voted, result_valid, pass, yes_cnt out.
module vote_round_ctrl
  import vote_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50,
  parameter int SHOW_CYCLES   = 20,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
  output logic       busy,
  output logic       voting,
  output logic [2:0] voted,
  output logic       result_valid,
  output logic       pass,
  output logic [1:0] yes_cnt
);

  localparam logic [CNT_W-1:0] WIN_LD  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       voted_q;
  logic [2:0]       voted_d;
  logic [2:0]       rise;
  logic             busy_q;
  logic             voting_q;
  logic             rv_q;
  logic             pass_q;
  logic [1:0]       yes_q;
  logic             maj;

  btn_sync_edge u_sync_a (.clk(clk), .rst(rst), .btn_i(btn_a), .rise_o(rise[0]));
  btn_sync_edge u_sync_b (.clk(clk), .rst(rst), .btn_i(btn_b), .rise_o(rise[1]));
  btn_sync_edge u_sync_c (.clk(clk), .rst(rst), .btn_i(btn_c), .rise_o(rise[2]));

  voter_33 u_voter (.a(voted_q[0]), .b(voted_q[1]), .c(voted_q[2]), .y(maj));

  // Sticky votes; only consumed while VOTING, so edges elsewhere are dropped.
  always_comb begin
    voted_d = voted_q | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      voted_q  <= '0;
      busy_q   <= 1'b0;
      voting_q <= 1'b0;
      rv_q     <= 1'b0;
      pass_q   <= 1'b0;
      yes_q    <= '0;
    end else begin
      rv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= VOTING;
            voted_q  <= '0;
            cnt_q    <= WIN_LD;
            busy_q   <= 1'b1;
            voting_q <= 1'b1;
          end
        end
        VOTING: begin
          voted_q <= voted_d;
          // Close on timeout or once every judge has voted, this cycle included.
          if (cnt_q == '0 || voted_d == ALL_VOTED) begin
            state_q  <= TALLY;
            voting_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        TALLY: begin
          pass_q  <= maj;
          yes_q   <= popcnt3(voted_q);
          rv_q    <= 1'b1;
          cnt_q   <= SHOW_LD;
          state_q <= SHOW;
        end
        SHOW: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign voting       = voting_q;
  assign voted        = voted_q;
  assign result_valid = rv_q;
  assign pass         = pass_q;
  assign yes_cnt      = yes_q;

endmodule
